uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver; next generation of the uart_top receive path.
//  Recovers frames from the serial line using an OVERSAMPLE x baud tick, with 3-sample majority voting.
//  Supports parameterised data width, runtime parity mode and 1/2 stop bits.
//  Reports framing, parity, break and overrun errors, and hands bytes to the core over a valid/ready interface.
// PARAMETERS
//  DATA_W      8    data bits per frame, 5..9, sent LSB first
//  OVERSAMPLE  16   os_tick pulses per bit period, even, >=8
//  STOP_BITS   1    stop bits checked, 1 or 2
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous, active-low reset
//  os_tick     in   1       one-clk pulse at OVERSAMPLE x baud rate, from the baud generator
//  rx          in   1       asynchronous serial input, idle high
//  cfg_parity  in   2       00 none, 01 even, 10 odd, 11 treated as none
//  rx_ready    in   1       core accepts rx_data this cycle when rx_valid=1
//  rx_data     out  DATA_W  received word
//  rx_valid    out  1       rx_data/err flags valid; held until accepted
//  frame_err   out  1       stop bit sampled 0 (qualified by rx_valid)
//  parity_err  out  1       parity mismatch (qualified by rx_valid)
//  break_det   out  1       1-clk pulse: data all 0, parity bit 0 (if enabled), stop 0
//  overrun     out  1       1-clk pulse: frame completed while holding register full
//  rx_busy     out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, tick counter 0, synchroniser flops 1.
//  - rx passes through a 2-FF synchroniser; all decisions use the synchronised signal (rxs).
//  - FSM states: IDLE, START, DATA, PARITY, STOP. Counters advance only on os_tick.
//  - IDLE: a 1->0 transition on rxs goes to START and clears the tick counter.
//  - Majority vote: each bit value is the majority of rxs at ticks OVERSAMPLE/2-1, /2 and /2+1.
//  - START: at tick OVERSAMPLE/2+1, a vote of 1 is a false start -> IDLE with no flags.
//    A vote of 0 latches cfg_parity into a frame-local register (mid-frame cfg changes are ignored),
//    then moves to DATA at the end of the bit period.
//  - DATA: DATA_W bits shifted in LSB first.
//    Then PARITY if the latched mode is 01 or 10, else STOP.
//  - PARITY: even mode requires XOR(data,p)=0; odd mode requires it to be 1. A mismatch sets the parity_err candidate.
//  - STOP: STOP_BITS bit periods. Any stop vote of 0 sets the frame_err candidate.
//    The FSM returns to IDLE right after the vote of the last stop bit, so a back-to-back start edge is caught.
//  - Completion (the clk after the last stop vote):
//    - Holding register empty, or rx_ready=1 that cycle: load rx_data and err flags; rx_valid=1.
//    - Otherwise: the new frame is discarded, the old data and flags are kept, and overrun pulses for 1 clk.
//  - Accept: rx_valid & rx_ready clears rx_valid on the next clk, unless a completion reloads it in the same cycle.
//  - break_det pulses at completion regardless of holding-register state; frame_err is also set if loaded.
//  - Tick counter width is $clog2(OVERSAMPLE); it wraps at OVERSAMPLE-1 -> 0 at every bit boundary.
//  - os_tick absent: the FSM holds state indefinitely (no timeout).
//  - reset_n low mid-frame: immediate return to reset values; the partial frame is lost.
// STRUCTURE
//  - uart_pkg: parity-mode localparams (PAR_NONE/EVEN/ODD) and FSM state encodings, shared with the TX path.
//  - Sub-module uart_rx_sync: 2-FF synchroniser plus 3-tap sample shift register and majority output.
//  - FSM, counters and holding register live in this module.
// TESTING
//  clk 50 MHz (#10), os_tick every 27 clk (~115200x16), defaults unless stated.
//  1 0xA5, cfg 00, rx_ready=1 -> rx_valid one clk after the stop vote, rx_data=0xA5, no error flags.
//  2 0xC3 with even parity, p=0; then 0xC3 with p=1 -> 1st frame parity_err=0; 2nd parity_err=1, data=0xC3.
//  3 0xD5 with stop bit driven 0 -> frame_err=1. 11 bit-times of rx=0 -> break_det pulse, rx_data=0x00.
//  4 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse; then ready -> rx_valid drops.
//  5 rx low for 4 ticks only -> back to IDLE, rx_valid stays 0, rx_busy high for <=OVERSAMPLE/2+2 ticks.
//  6 DATA_W=7, STOP_BITS=2, odd parity, 0x5A; reset_n pulsed mid-DATA -> first frame lost, no flags.
//    Next frame 0x3C is received clean.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, FSM state encodings and a
// 3-input majority helper used by both the RX and TX paths.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Mode 2'b11 is deliberately treated as no parity.
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line, falling-edge detect on the
// synchronised signal, and a 3-sample majority vote taken on os_tick.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic os_tick,
   input  logic rx,
   output logic rxs,
   output logic rx_fall,
   output logic vote
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       prev_q, prev_d;
   logic [1:0] taps_q, taps_d;

   always_comb begin
      sync1_d = rx;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      taps_d  = taps_q;
      if (os_tick) taps_d = {taps_q[0], sync2_q};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         taps_q  <= 2'b11;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         taps_q  <= taps_d;
      end
   end

   // Vote combines the two previous tick samples with the live one, so on the
   // vote tick it covers ticks N-2, N-1 and N.
   assign rxs     = sync2_q;
   assign rx_fall = prev_q & ~sync2_q;
   assign vote    = maj3(taps_q[1], taps_q[0], sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver: oversampled start/data/parity/stop recovery with majority
// voting, single-entry holding register and framing/parity/break/overrun flags.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a falling edge on rxs
// ST_START  | validating start bit; parity mode latched on a good vote
// ST_DATA   | shifting DATA_W bits in, LSB first
// ST_PARITY | sampling and checking the parity bit
// ST_STOP   | sampling STOP_BITS stop bits; leaves right after the last vote
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              os_tick,
   input  logic              rx,
   input  logic [1:0]        cfg_parity,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              parity_err,
   output logic              break_det,
   output logic              overrun,
   output logic              rx_busy
);

   localparam int              CNT_W     = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   logic rxs, rx_fall, vote;

   uart_rx_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .os_tick (os_tick),
      .rx      (rx),
      .rxs     (rxs),
      .rx_fall (rx_fall),
      .vote    (vote)
   );

   uart_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [1:0]        mode_q, mode_d;
   logic              par_bit_q, par_bit_d;
   logic              perr_c_q, perr_c_d;
   logic              ferr_c_q, ferr_c_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              parity_err_q, parity_err_d;
   logic              break_q, break_d;
   logic              overrun_q, overrun_d;
   logic              busy_q, busy_d;

   logic tick_vote, tick_end, brk_c;

   assign tick_vote = os_tick && (cnt_q == CNT_VOTE);
   assign tick_end  = os_tick && (cnt_q == CNT_LAST);
   assign brk_c     = (shreg_q == '0) && (!par_enabled(mode_q) || !par_bit_q) && ferr_c_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      mode_d       = mode_q;
      par_bit_d    = par_bit_q;
      perr_c_d     = perr_c_q;
      ferr_c_d     = ferr_c_q;
      done_d       = 1'b0;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      break_d      = 1'b0;
      overrun_d    = 1'b0;

      if (os_tick && state_q != ST_IDLE)
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               state_d  = ST_START;
               cnt_d    = '0;
               bit_d    = '0;
               perr_c_d = 1'b0;
               ferr_c_d = 1'b0;
            end
         end
         ST_START: begin
            if (tick_vote) begin
               if (vote) state_d = ST_IDLE;
               else      mode_d  = cfg_parity;
            end else if (tick_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick_vote) shreg_d = {vote, shreg_q[DATA_W-1:1]};
            if (tick_end) begin
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = par_enabled(mode_q) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (tick_vote) begin
               par_bit_d = vote;
               perr_c_d  = ((^shreg_q) ^ vote) != (mode_q == PAR_ODD);
            end
            if (tick_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (tick_vote) begin
               if (!vote) ferr_c_d = 1'b1;
               if (bit_q == STOP_LAST) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (tick_end) begin
               bit_d = bit_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      // A completing frame may reload in the same cycle the old word is taken.
      if (done_q) begin
         break_d = brk_c;
         if (!rx_valid_q || rx_ready) begin
            rx_data_d    = shreg_q;
            frame_err_d  = ferr_c_q;
            parity_err_d = perr_c_q;
            rx_valid_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         mode_q       <= PAR_NONE;
         par_bit_q    <= 1'b0;
         perr_c_q     <= 1'b0;
         ferr_c_q     <= 1'b0;
         done_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         break_q      <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         mode_q       <= mode_d;
         par_bit_q    <= par_bit_d;
         perr_c_q     <= perr_c_d;
         ferr_c_q     <= ferr_c_d;
         done_q       <= done_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         break_q      <= break_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign break_det  = break_q;
   assign overrun    = overrun_q;
   assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a default 8N1 instance driven from a vector
// table plus hand sequences, and a 7-bit / 2-stop instance for the reset case.
module tb_uart_rx_cfg;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       os_tick = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] cfg_parity = 2'b00;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, break_det, overrun, rx_busy;

   logic       rst7_n = 1'b0;
   logic       rx7 = 1'b1;
   logic [1:0] cfg7 = 2'b10;
   logic       ready7 = 1'b0;
   logic [6:0] rx_data7;
   logic       rx_valid7, frame_err7, parity_err7, break_det7, overrun7, rx_busy7;

   uart_rx_cfg dut (
      .clk(clk), .reset_n(reset_n), .os_tick(os_tick), .rx(rx),
      .cfg_parity(cfg_parity), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .frame_err(frame_err), .parity_err(parity_err),
      .break_det(break_det), .overrun(overrun), .rx_busy(rx_busy)
   );

   uart_rx_cfg #(.DATA_W(7), .OVERSAMPLE(16), .STOP_BITS(2)) dut7 (
      .clk(clk), .reset_n(rst7_n), .os_tick(os_tick), .rx(rx7),
      .cfg_parity(cfg7), .rx_ready(ready7), .rx_data(rx_data7),
      .rx_valid(rx_valid7), .frame_err(frame_err7), .parity_err(parity_err7),
      .break_det(break_det7), .overrun(overrun7), .rx_busy(rx_busy7)
   );

   always #10 clk = ~clk;

   initial begin
      forever begin
         repeat (26) @(posedge clk);
         #1 os_tick = 1'b1;
         @(posedge clk);
         #1 os_tick = 1'b0;
      end
   end

   int checks = 0;
   int failures = 0;

   int         cyc = 0, acc_cnt = 0, brk_cnt = 0, ovr_cnt = 0, busy_clks = 0;
   int         t_valid = 0;
   logic       valid_prev = 1'b0;
   logic [7:0] cap_data = '0;
   logic       cap_perr = 1'b0, cap_ferr = 1'b0;
   int         acc7 = 0, brk7 = 0, ovr7 = 0;
   logic [6:0] cap_data7 = '0;
   logic       cap_perr7 = 1'b0, cap_ferr7 = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      valid_prev <= rx_valid;
      if (rx_valid && !valid_prev) t_valid <= cyc;
      if (rx_valid && rx_ready) begin
         acc_cnt  <= acc_cnt + 1;
         cap_data <= rx_data;
         cap_perr <= parity_err;
         cap_ferr <= frame_err;
      end
      if (break_det) brk_cnt <= brk_cnt + 1;
      if (overrun)   ovr_cnt <= ovr_cnt + 1;
      if (rx_busy)   busy_clks <= busy_clks + 1;
      if (rx_valid7 && ready7) begin
         acc7      <= acc7 + 1;
         cap_data7 <= rx_data7;
         cap_perr7 <= parity_err7;
         cap_ferr7 <= frame_err7;
      end
      if (break_det7) brk7 <= brk7 + 1;
      if (overrun7)   ovr7 <= ovr7 + 1;
   end

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo,
                              input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!os_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic drive(input logic v, input bit use7);
      if (use7) rx7 = v;
      else      rx  = v;
   endtask

   int t_stop = 0;

   // Parity mode is scrambled after the start bit to show the frame keeps the
   // mode it latched at the start vote.
   task automatic send_frame(input logic [8:0] data, input int nbits, input logic [1:0] cfg,
                             input logic pen, input logic pbit, input logic stop_val,
                             input int nstop, input bit use7);
      if (use7) cfg7 = cfg;
      else      cfg_parity = cfg;
      drive(1'b0, use7);
      wait_ticks(16);
      if (!use7) cfg_parity = (cfg == 2'b01 || cfg == 2'b10) ? 2'b00 : 2'b01;
      for (int i = 0; i < nbits; i++) begin
         drive(data[i], use7);
         wait_ticks(16);
      end
      if (pen) begin
         drive(pbit, use7);
         wait_ticks(16);
      end
      for (int s = 0; s < nstop; s++) begin
         if (s == nstop - 1) t_stop = cyc;
         drive(stop_val, use7);
         wait_ticks(16);
      end
      if (!stop_val) wait_ticks(16);
      drive(1'b1, use7);
      if (use7) cfg7 = cfg;
      else      cfg_parity = cfg;
      wait_ticks(32);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [1:0] cfg;
      logic       pen;
      logic       pbit;
      logic       stop_val;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
      logic       exp_brk;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int a0, b0, o0, bz0;

      vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hC3, 2'b01, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'hC3, 2'b01, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h01, 2'b10, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h01, 2'b11, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{8'hD5, 2'b00, 1'b0, 1'b0, 1'b0, 8'hD5, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

      repeat (5) @(posedge clk);
      #1;
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_flags", {frame_err, parity_err, break_det, overrun}, 0);
      check("reset_rx_busy", rx_busy, 0);
      check("reset_dut7_busy_valid", {rx_busy7, rx_valid7}, 0);
      reset_n  = 1'b1;
      rst7_n   = 1'b1;
      rx_ready = 1'b1;
      ready7   = 1'b1;
      wait_ticks(4);

      for (int v = 0; v < 8; v++) begin
         a0 = acc_cnt;
         b0 = brk_cnt;
         send_frame({1'b0, vecs[v].data}, 8, vecs[v].cfg, vecs[v].pen, vecs[v].pbit,
                    vecs[v].stop_val, 1, 1'b0);
         check($sformatf("v%0d_accepted", v), acc_cnt - a0, 1);
         check($sformatf("v%0d_data", v), cap_data, vecs[v].exp_data);
         check($sformatf("v%0d_parity_err", v), cap_perr, vecs[v].exp_perr);
         check($sformatf("v%0d_frame_err", v), cap_ferr, vecs[v].exp_ferr);
         check($sformatf("v%0d_break_pulses", v), brk_cnt - b0, vecs[v].exp_brk);
         check_range($sformatf("v%0d_valid_latency_clk", v), t_valid - t_stop, 269, 274);
      end

      // Overrun: holding register full, second frame dropped.
      rx_ready = 1'b0;
      a0 = acc_cnt;
      o0 = ovr_cnt;
      send_frame(9'h011, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      check("ovr_first_valid", rx_valid, 1);
      check("ovr_first_data", rx_data, 8'h11);
      send_frame(9'h022, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      check("ovr_data_kept", rx_data, 8'h11);
      check("ovr_valid_held", rx_valid, 1);
      check("ovr_pulses", ovr_cnt - o0, 1);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("ovr_valid_dropped", rx_valid, 0);
      check("ovr_accepted", acc_cnt - a0, 1);

      // False start: 4 ticks low.
      a0  = acc_cnt;
      bz0 = busy_clks;
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(4);
      rx = 1'b1;
      wait_ticks(20);
      check_range("false_start_busy_clk", busy_clks - bz0, 1, 10 * 27);
      check("false_start_valid", rx_valid, 0);
      check("false_start_accepted", acc_cnt - a0, 0);
      check("false_start_idle", rx_busy, 0);

      // 7-bit, 2 stop, odd parity: reset mid-data, then a clean frame.
      wait_ticks(1);
      cfg7 = 2'b10;
      rx7 = 1'b0;
      wait_ticks(16);
      rx7 = 1'b0; wait_ticks(16);
      rx7 = 1'b1; wait_ticks(16);
      rx7 = 1'b0; wait_ticks(8);
      check("d7_busy_mid_frame", rx_busy7, 1);
      rst7_n = 1'b0;
      rx7 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("d7_busy_in_reset", rx_busy7, 0);
      rst7_n = 1'b1;
      wait_ticks(48);
      check("d7_lost_frame_accepts", acc7, 0);
      check("d7_lost_frame_flags", {brk7 != 0, ovr7 != 0, rx_valid7}, 0);
      send_frame(9'h03C, 7, 2'b10, 1'b1, 1'b1, 1'b1, 2, 1'b1);
      check("d7_accepted", acc7, 1);
      check("d7_data", cap_data7, 7'h3C);
      check("d7_parity_err", cap_perr7, 0);
      check("d7_frame_err", cap_ferr7, 0);
      check("d7_no_break_overrun", brk7 + ovr7, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
